// File: rtl/audio_proc_pkg.sv
// Shared constants and FSM state type for the audio frame driver.
// Frame geometry derives from sample width and processor word width.
package audio_proc_pkg;

  localparam int SIZE       = 16;
  localparam int INPUT_SIZE = 512;
  localparam int SAMPLES    = 2048;
  localparam int RD_LAT     = 1;
  localparam int SPW        = INPUT_SIZE / SIZE;
  localparam int WPF        = SAMPLES / SPW;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_WRITE,
    ST_START,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_FETCH,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/audio_frame_driver_if.sv
// Sample streams plus processor word read/write/start bundle.
// master = the driver, slave = the surrounding environment.
interface audio_frame_driver_if #(
  parameter int SIZE       = audio_proc_pkg::SIZE,
  parameter int INPUT_SIZE = audio_proc_pkg::INPUT_SIZE,
  parameter int IDXW       = $clog2(audio_proc_pkg::WPF)
);

  logic                  in_valid;
  logic                  in_ready;
  logic [SIZE-1:0]       in_sample;
  logic                  out_valid;
  logic                  out_ready;
  logic [SIZE-1:0]       out_sample;
  logic                  ap_data_wr_en;
  logic [IDXW-1:0]       ap_input_index;
  logic [INPUT_SIZE-1:0] ap_data_in;
  logic                  ap_start;
  logic                  ap_done;
  logic [IDXW-1:0]       ap_output_index;
  logic [INPUT_SIZE-1:0] ap_data_out;

  modport master (
    input  in_valid, in_sample, out_ready,
    input  ap_done, ap_data_out,
    output in_ready, out_valid, out_sample,
    output ap_data_wr_en, ap_input_index, ap_data_in,
    output ap_start, ap_output_index
  );

  modport slave (
    output in_valid, in_sample, out_ready,
    output ap_done, ap_data_out,
    input  in_ready, out_valid, out_sample,
    input  ap_data_wr_en, ap_input_index, ap_data_in,
    input  ap_start, ap_output_index
  );

endinterface

// File: rtl/audio_frame_driver_sample_unpacker.sv
// Holds one processed word and streams its samples out,
// slot 0 first, with a stall-stable valid/ready handshake.
module sample_unpacker #(
  parameter int SIZE       = audio_proc_pkg::SIZE,
  parameter int INPUT_SIZE = audio_proc_pkg::INPUT_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_load,
  input  logic [INPUT_SIZE-1:0] i_word,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [SIZE-1:0]       o_sample,
  output logic                  o_last
);

  localparam int SW = $clog2(INPUT_SIZE / SIZE);
  localparam logic [SW-1:0] SLOT_LAST = SW'(INPUT_SIZE / SIZE - 1);

  logic [INPUT_SIZE-1:0] r_unpack;
  logic [SW-1:0]         r_slot;
  logic                  r_valid;
  logic                  w_take;

  assign w_take   = r_valid && i_ready;
  assign o_last   = w_take && (r_slot == SLOT_LAST);
  assign o_valid  = r_valid;
  assign o_sample = r_unpack[int'(r_slot)*SIZE +: SIZE];

  // load a fresh word, then step through its slots on each take
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_unpack <= '0;
      r_slot   <= '0;
      r_valid  <= 1'b0;
    end else if (i_load) begin
      r_unpack <= i_word;
      r_slot   <= '0;
      r_valid  <= 1'b1;
    end else if (w_take) begin
      if (r_slot == SLOT_LAST) begin
        r_slot  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_slot <= r_slot + 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_frame_driver.sv
// Packs a sample frame into processor words, runs the processor,
// then unpacks its result words back into a sample stream.
module audio_frame_driver #(
  parameter int SIZE       = audio_proc_pkg::SIZE,
  parameter int INPUT_SIZE = audio_proc_pkg::INPUT_SIZE,
  parameter int SAMPLES    = audio_proc_pkg::SAMPLES,
  parameter int RD_LAT     = audio_proc_pkg::RD_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
  audio_frame_driver_if.master bus,
  output logic [15:0]         frame_count,
  output logic                busy
);

  import audio_proc_pkg::*;

  localparam int L_SPW = INPUT_SIZE / SIZE;
  localparam int L_WPF = SAMPLES / L_SPW;
  localparam int SW    = $clog2(L_SPW);
  localparam int IW    = $clog2(L_WPF);
  localparam int LW    = $clog2(RD_LAT + 2);
  localparam logic [SW-1:0] SLOT_LAST = SW'(L_SPW - 1);
  localparam logic [IW-1:0] WORD_LAST = IW'(L_WPF - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(RD_LAT);

  state_t                r_state;
  state_t                w_next;
  logic [SW-1:0]         r_slot;
  logic [IW-1:0]         r_word;
  logic [LW-1:0]         r_lat;
  logic [INPUT_SIZE-1:0] r_pack;
  logic [15:0]           r_frame_count;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_last;

  assign w_accept    = (r_state == ST_FILL) && bus.in_valid;
  assign w_load      = (r_state == ST_FETCH) && (r_lat == LAT_LAST);
  assign busy        = (r_state != ST_FILL);
  assign frame_count = r_frame_count;

  sample_unpacker #(
    .SIZE       (SIZE),
    .INPUT_SIZE (INPUT_SIZE)
  ) u_unpack (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_word   (bus.ap_data_out),
    .i_ready  (bus.out_ready),
    .o_valid  (bus.out_valid),
    .o_sample (bus.out_sample),
    .o_last   (w_last)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_FILL;
    else        r_state <= w_next;
  end

  // next state; a done level left over from before start is
  // ignored until it has been seen low
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_FILL:
        if (w_accept && r_slot == SLOT_LAST) w_next = ST_WRITE;
      ST_WRITE:
        w_next = (r_word == WORD_LAST) ? ST_START : ST_FILL;
      ST_START:
        w_next = ST_WAIT_LOW;
      ST_WAIT_LOW:
        if (!bus.ap_done) w_next = ST_WAIT_HIGH;
      ST_WAIT_HIGH:
        if (bus.ap_done) w_next = ST_FETCH;
      ST_FETCH:
        if (w_load) w_next = ST_DRAIN;
      ST_DRAIN:
        if (w_last)
          w_next = (r_word == WORD_LAST) ? ST_FILL : ST_FETCH;
      default:
        w_next = ST_FILL;
    endcase
  end

  // state-decoded outputs toward the stream and processor
  always_comb begin
    bus.in_ready        = 1'b0;
    bus.ap_data_wr_en   = 1'b0;
    bus.ap_input_index  = '0;
    bus.ap_data_in      = '0;
    bus.ap_start        = 1'b0;
    bus.ap_output_index = '0;
    unique case (r_state)
      ST_FILL:  bus.in_ready = 1'b1;
      ST_WRITE: begin
        bus.ap_data_wr_en  = 1'b1;
        bus.ap_input_index = r_word;
        bus.ap_data_in     = r_pack;
      end
      ST_START: bus.ap_start = 1'b1;
      ST_FETCH: bus.ap_output_index = r_word;
      default: ;
    endcase
  end

  // pack register, slot/word/latency counters, frame counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot        <= '0;
      r_word        <= '0;
      r_lat         <= '0;
      r_pack        <= '0;
      r_frame_count <= '0;
    end else begin
      if (w_accept) begin
        r_pack[int'(r_slot)*SIZE +: SIZE] <= bus.in_sample;
        r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;
      end
      if (r_state == ST_WRITE)
        r_word <= (r_word == WORD_LAST) ? '0 : r_word + 1'b1;
      if (r_state == ST_WAIT_HIGH)
        r_word <= '0;
      if (r_state == ST_FETCH)
        r_lat <= w_load ? '0 : r_lat + 1'b1;
      if (r_state == ST_DRAIN && w_last) begin
        r_word <= (r_word == WORD_LAST) ? '0 : r_word + 1'b1;
        if (r_word == WORD_LAST)
          r_frame_count <= r_frame_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/audio_frame_driver.md
AUDIO_FRAME_DRIVER -- requirements
Module: audio_frame_driver

Interface
REQ-001 Parameters: SIZE default 16 (sample bits); INPUT_SIZE default 512 (word bits); SAMPLES default 2048 (samples per frame); RD_LAT default 1 (cycles from ap_output_index to valid ap_data_out).
REQ-002 Derived: SPW = INPUT_SIZE/SIZE (32 samples per word); WPF = SAMPLES/SPW (64 words per frame).
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 in_valid  in  1  / in_ready  out  1 / in_sample  in  SIZE  input sample stream, transfer when valid&ready.
REQ-006 out_valid  out  1 / out_ready  in  1 / out_sample  out  SIZE  processed sample stream, transfer when valid&ready.
REQ-007 ap_data_wr_en  out  1 / ap_input_index  out  log2(WPF) / ap_data_in  out  INPUT_SIZE  word write port to processor.
REQ-008 ap_start  out  1  one-cycle start pulse; ap_done  in  1  processor idle/result-ready level.
REQ-009 ap_output_index  out  log2(WPF) / ap_data_out  in  INPUT_SIZE  word read port from processor.
REQ-010 frame_count  out  16  completed frames, wraps at 65535->0; busy  out  1  high in every state except FILL.

Function
REQ-011 States: FILL, WRITE, START, WAIT_LOW, WAIT_HIGH, FETCH, DRAIN.
REQ-012 FILL: in_ready=1; each accepted sample goes to slot k of the pack register, bits [SIZE*k+SIZE-1 : SIZE*k], k incrementing 0..SPW-1; accepting slot SPW-1 -> WRITE.
REQ-013 WRITE: exactly one cycle with ap_data_wr_en=1, ap_input_index=word counter, ap_data_in=pack register; in_ready=0; word counter increments; if it was WPF-1 -> START, else -> FILL.
REQ-014 START: ap_start=1 for exactly one cycle -> WAIT_LOW.
REQ-015 WAIT_LOW: hold until ap_done=0, then -> WAIT_HIGH; a done still high from before start is never treated as completion.
REQ-016 WAIT_HIGH: hold until ap_done=1, then -> FETCH with word counter=0.
REQ-017 FETCH: drive ap_output_index=word counter; RD_LAT cycles later load ap_data_out into the unpack register -> DRAIN.
REQ-018 DRAIN: out_valid=1, out_sample=unpack slot k (same bit map as REQ-012), k advances on each out_ready; after slot SPW-1 is taken, word counter increments; if it was WPF-1, frame_count increments and -> FILL, else -> FETCH.
REQ-019 out_sample and out_valid stay stable while out_valid=1 and out_ready=0.
REQ-020 Sample order preserved end-to-end: input sample n maps to word n/SPW, slot n%SPW; output in identical order.
REQ-021 ap_data_wr_en and ap_start are never high in the same cycle; neither is high outside WRITE/START.
REQ-022 in_ready=0 in every state except FILL; out_valid=0 in every state except DRAIN.
REQ-023 Throughput: one frame in = SAMPLES accepted + WPF write cycles minimum; drain = SAMPLES + WPF*(RD_LAT+1) cycles minimum.

Reset
REQ-024 rst_n=0 at a clock edge: state=FILL, slot and word counters=0, frame_count=0, in_ready=1 on the first cycle after release, all other outputs 0.
REQ-025 Reset mid-frame discards partial pack/unpack contents and all progress; the next accepted sample is slot 0 of word 0.

Structure
REQ-026 The shared package audio_proc_pkg holds SIZE, INPUT_SIZE, SAMPLES, SPW, WPF and the state enum type.
REQ-027 One sub-module, sample_unpacker, holds the unpack register, slot counter and output handshake; the packing path stays in the top level.

Verification
REQ-028 Ramp: feed samples 0..2047 with an echo-model processor (data_out = written word); out stream = 0..2047 in order; frame_count=1.
REQ-029 Packing: samples 0x0001..0x0020 -> one WRITE with ap_input_index=0 and ap_data_in[15:0]=0x0001, [511:496]=0x0020.
REQ-030 Done handshake: ap_done held high for 5 cycles after start, then low 10, then high -> no FETCH before the falling edge; first ap_output_index=0 one cycle after the rise.
REQ-031 Backpressure: out_ready toggled randomly (50%) -> no sample lost or duplicated, out_sample stable while stalled.
REQ-032 Reset after 1000 input samples -> all outputs at reset values, frame_count=0; a new 2048-sample frame completes correctly.
REQ-033 Wrap: preset frame_count 65535 via force, run one frame -> frame_count=0.
